// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared constants, types and helpers for the cascadable
//                two-digit BCD counter.
//                  BCD_MAX_DIGIT : largest legal BCD digit (9)
//                  DIGIT_W       : width of one BCD digit
//                  DEFAULT_MOD   : customary modulus (sixty) for time-style use
//  Revision    : 1.0  initial release
// ============================================================================
package counter_pkg;

    localparam int              DIGIT_W       = 4;
    localparam logic [3:0]      BCD_MAX_DIGIT = 4'd9;
    localparam logic [7:0]      DEFAULT_MOD   = 8'h60;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t units;
    } bcd_pair_t;

    // Binary magnitude of a two-digit BCD pair. Digits are taken at face
    // value (an illegal 0xC counts as twelve), so an out-of-range load still
    // compares as "large". Worst case 15*10+15 = 165 fits in 8 bits.
    function automatic logic [7:0] bcd_to_bin(input bcd_pair_t v);
        return (8'(v.tens) * 8'd10) + 8'(v.units);
    endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : Combinational next-value logic for one BCD digit.
//  Ports       : i_digit [3:0] - current digit value (may be illegal, >9)
//                i_ci          - carry in; when high the digit increments
//                o_nxt   [3:0] - next digit value
//                o_co          - carry out; digit rolled from 9 to 0
//  Notes       : An illegal digit (>9) is treated as 9 when incrementing, so
//                it rolls to 0 and carries. Without carry-in the digit is
//                passed through unchanged, illegal value included.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit
    import counter_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    input  logic               i_ci,
    output logic [DIGIT_W-1:0] o_nxt,
    output logic               o_co
);

    logic [DIGIT_W-1:0] w_eff;

    always_comb begin
        w_eff = (i_digit > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : i_digit;
        o_nxt = i_digit;
        o_co  = 1'b0;
        if (i_ci) begin
            if (w_eff == BCD_MAX_DIGIT) begin
                o_nxt = '0;
                o_co  = 1'b1;
            end else begin
                o_nxt = w_eff + 1'b1;
            end
        end
    end

endmodule : bcd_digit
`default_nettype wire

// File: rtl/cascade_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cascade_bcd_counter
//  Description : Two-digit BCD counter intended to sit behind a 4-bit
//                upstream counter in a cascade. Programmable modulus,
//                synchronous parallel load, combinational carry out and a
//                registered terminal-count pulse.
//  Parameters  : RST_VAL   - BCD value loaded into Q by reset
//  Ports       : CP        - rising-edge clock (shared with upstream stage)
//                CR        - asynchronous active-low reset
//                LD        - synchronous active-low parallel load
//                EN        - count enable (upstream carry, level sampled)
//                D   [7:0] - BCD load value, [7:4] tens, [3:0] units
//                BCD modulus on port MOD [7:0]; 8'h00 selects modulus 100
//                Q   [7:0] - registered BCD count
//                Co        - combinational carry to the next stage
//                TC        - one-cycle pulse the cycle after a wrap
//  Revision    : 1.0  initial release
// ============================================================================
module cascade_bcd_counter
    import counter_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'h00
)
(
    input  logic       CP,
    input  logic       CR,
    input  logic       LD,
    input  logic       EN,
    input  logic [7:0] D,
    input  logic [7:0] MOD,
    output logic [7:0] Q,
    output logic       Co,
    output logic       TC
);

    logic [7:0]         r_q;
    logic               r_tc;

    logic [DIGIT_W-1:0] w_units_nxt;
    logic               w_units_co;
    logic [DIGIT_W-1:0] w_tens_nxt;
    logic               w_tens_co;
    logic [7:0]         w_inc;
    logic               w_mod_active;
    logic               w_hit_mod;
    logic               w_over_mod;
    logic               w_wrap;

    // Units always see a carry-in: this stage only advances on enabled
    // edges, and the increment is discarded otherwise.
    bcd_digit u_units (
        .i_digit (r_q[3:0]),
        .i_ci    (1'b1),
        .o_nxt   (w_units_nxt),
        .o_co    (w_units_co)
    );

    bcd_digit u_tens (
        .i_digit (r_q[7:4]),
        .i_ci    (w_units_co),
        .o_nxt   (w_tens_nxt),
        .o_co    (w_tens_co)
    );

    assign w_inc        = {w_tens_nxt, w_units_nxt};
    assign w_mod_active = (MOD != 8'h00);

    // Normal terminal count: the incremented value lands on the modulus.
    assign w_hit_mod    = (w_inc == MOD);

    // Recovery from a value already at or beyond the modulus (typically an
    // out-of-range load, or MOD lowered underneath a running count).
    assign w_over_mod   = (bcd_to_bin(bcd_pair_t'(r_q)) >= bcd_to_bin(bcd_pair_t'(MOD)));

    // A tens roll-over (99 -> 00) is always a wrap; with MOD=00 it is the
    // only one.
    assign w_wrap = w_tens_co | (w_mod_active & (w_hit_mod | w_over_mod));

    // Kept purely combinational so a downstream stage sees the carry in the
    // same cycle as EN; CR gating keeps it quiet during reset.
    assign Co = EN & CR & LD & w_wrap;

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            r_q  <= RST_VAL;
            r_tc <= 1'b0;
        end else if (!LD) begin
            r_q  <= D;
            r_tc <= 1'b0;
        end else if (EN) begin
            r_q  <= w_wrap ? 8'h00 : w_inc;
            r_tc <= w_wrap;
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign Q  = r_q;
    assign TC = r_tc;

endmodule : cascade_bcd_counter
`default_nettype wire

// File: doc/cascade_bcd_counter.md
CASCADE_BCD_COUNTER -- requirements
Module: cascade_bcd_counter

Interface
REQ-001 SHALL have parameter RST_VAL, default 8'h00, two-digit BCD value taken by Q on reset.
REQ-002 SHALL have port CP  input  1  rising-edge clock, the same clock as the upstream 4-bit counter.
REQ-003 SHALL have port CR  input  1  asynchronous active-low reset.
REQ-004 SHALL have port LD  input  1  synchronous active-low parallel load.
REQ-005 SHALL have port EN  input  1  count enable; driven by upstream Co, a level sampled on CP.
REQ-006 SHALL have port D  input  8  BCD load value; [7:4] is tens, [3:0] is units.
REQ-007 SHALL have port MOD  input  8  BCD modulus; 8'h00 means modulus 100.
REQ-008 SHALL have port Q  output  8  registered BCD count.
REQ-009 SHALL have port Co  output  1  combinational carry to the next cascade stage.
REQ-010 SHALL have port TC  output  1  registered one-cycle pulse, asserted the cycle after a wrap.

Function
REQ-011 SHALL apply this priority on each CP rising edge: CR low, then LD low, then EN high, then hold.
REQ-012 SHALL load Q <= D when LD=0, independent of EN.
REQ-013 SHALL count with EN=1, LD=1: units +1; units 9->0 with tens +1; tens 9->0 on 99.
REQ-014 SHALL set Q <= 8'h00 on an enabled edge when the incremented value equals MOD; MOD=8'h00 wraps 99->00.
REQ-015 SHALL set Q <= 8'h00 on the next enabled edge if Q >= MOD numerically (MOD != 00), e.g. after an out-of-range load.
REQ-016 SHALL treat a units digit >9 (after load) as 9 when incrementing: the digit goes to 0 and carries into tens.
REQ-017 SHALL treat a tens digit >9 as 9 when incrementing: the digit goes to 0 and wraps Q.
REQ-018 SHALL drive Co = EN & CR & LD & (next enabled edge causes wrap per REQ-014/015), with no register stage.
REQ-019 SHALL assert TC for exactly one cycle following any edge on which Co was 1; a load clears TC on the next edge.
REQ-020 SHALL hold Q and deassert TC with EN=0 and LD=1, with MOD changes taking effect combinationally on Co.
REQ-021 SHALL have one-cycle latency from EN to Q change; Co is valid in the same cycle as EN.

Reset
REQ-022 SHALL force Q=RST_VAL and TC=0 immediately on CR falling edge, without waiting for CP.
REQ-023 SHALL hold Co=0 while CR=0.
REQ-024 SHALL ignore CP edges while CR=0; the first edge after CR rises obeys REQ-011.
REQ-025 SHALL discard any count in progress when reset occurs mid-count; there is no partial-carry state.

Structure
REQ-026 SHALL place BCD_MAX_DIGIT (4'd9), the digit width (4) and the default modulus 8'h60 in a shared package, counter_pkg.
REQ-027 SHALL use one sub-module, bcd_digit: a 4-bit BCD digit with ci input, next-value output and co output, instantiated twice.
REQ-028 SHALL implement the modulus compare and TC register in the top level, not in bcd_digit.

Verification
REQ-029 SHALL check reset: CR=0 mid-cycle with Q=8'h37 -> Q=8'h00 and TC=0 before the next CP; Co=0 while CR=0.
REQ-030 SHALL check mod-60: MOD=8'h60, EN=1, start 8'h58 -> 59 then 00; Co=1 during 59; TC=1 the cycle after.
REQ-031 SHALL check cascade: EN from upstream 4-bit Co (1 in 16 cycles), start 00 -> Q=8'h01 after 16 edges, 8'h10 after 160.
REQ-032 SHALL check load priority: LD=0 with EN=1, D=8'h42 -> Q=8'h42 and TC=0; a LD pulse with EN=0 also loads.
REQ-033 SHALL check out-of-range load: MOD=8'h24, load D=8'h30, EN=1 -> Q=8'h00 on the next edge and Co=1 beforehand.
REQ-034 SHALL check MOD=00 and an invalid digit: MOD=00 from 8'h99 wraps to 00 with Co=1; load 8'h0C, EN=1 -> Q=8'h10.
